// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix result serial transmitter.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_t;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam int         FRAME_BYTES  = 6;

  // Byte at position idx of the frame: header, four elements, then their sum mod 256.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [3:0][7:0] c);
    logic [7:0] b;
    case (idx)
      3'd0:    b = FRAME_HEADER;
      3'd1:    b = c[0];
      3'd2:    b = c[1];
      3'd3:    b = c[2];
      3'd4:    b = c[3];
      3'd5:    b = c[0] + c[1] + c[2] + c[3];
      default: b = FRAME_HEADER;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/matrix_result_tx_if.sv
// Bundle of request, data and serial-line signals of the result transmitter.
//
// Handshake: send is a level request sampled on every rising edge. It is
// accepted only when the transmitter is idle (busy=0, which includes the
// single done cycle); the four C elements are captured on that accepting
// edge. While busy=1, send and the C inputs are ignored. done pulses for one
// cycle after the last stop bit; busy is 0 in that cycle.
interface matrix_result_tx_if;
  import matmul_pkg::*;

  logic       send;
  logic [7:0] C00;
  logic [7:0] C01;
  logic [7:0] C10;
  logic [7:0] C11;
  logic       tx;
  logic       busy;
  logic       done;
  tx_state_t  dbg_state;

  modport master (
    output send, C00, C01, C10, C11,
    input  tx, busy, done, dbg_state
  );

  modport slave (
    input  send, C00, C01, C10, C11,
    output tx, busy, done, dbg_state
  );

endinterface

// File: rtl/matrix_result_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, tick on the last count.
module baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: restart on frame start, wrap on tick, park at zero when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matrix_result_tx.sv
// Serialises a captured 2x2 result matrix as a 6-byte UART 8N1 frame:
// header, C00, C01, C10, C11, checksum. Bytes go back-to-back.
module matrix_result_tx
  import matmul_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              nRST,
  matrix_result_tx_if.slave bus
);

  tx_state_t       state_q, state_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [3:0][7:0] data_q, data_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            start;
  logic            tick;
  logic [7:0]      byte_d;

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (nRST),
    .clear_i (start),
    .en_i    (state_q != IDLE),
    .tick_o  (tick)
  );

  // Next-state, counters, capture and next tx level (tx follows the next state so it leaves a flop).
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    done_d     = 1'b0;
    start      = 1'b0;
    tx_d       = 1'b1;
    byte_d     = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.send) begin
          start      = 1'b1;
          state_d    = START_BIT;
          data_d     = {bus.C11, bus.C10, bus.C01, bus.C00};
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
        end
      end
      START_BIT: begin
        if (tick) begin
          state_d   = DATA_BITS;
          bit_idx_d = 3'd0;
        end
      end
      DATA_BITS: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP_BIT: begin
        if (tick) begin
          if (byte_idx_q == 3'(FRAME_BYTES - 1)) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            byte_idx_d = 3'd0;
            bit_idx_d  = 3'd0;
          end else begin
            state_d    = START_BIT;
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    byte_d = frame_byte(byte_idx_d, data_d);
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA_BITS: tx_d = byte_d[bit_idx_d];
      default:   tx_d = 1'b1;
    endcase
  end

  // State, counters, captured data and output flops; reset aborts any frame.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      byte_idx_q <= 3'd0;
      bit_idx_q  <= 3'd0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_matrix_result_tx.sv
// Bench for matrix_result_tx: three instances (4, 2 and 16 clocks per bit)
// checked against a frame model built from the byte/bit framing rules.
module tb_matrix_result_tx;
  import matmul_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  matrix_result_tx_if if4();
  matrix_result_tx_if if2();
  matrix_result_tx_if if16();

  matrix_result_tx #(.CLKS_PER_BIT(4))  dut4  (.clk(clk), .nRST(nRST), .bus(if4));
  matrix_result_tx #(.CLKS_PER_BIT(2))  dut2  (.clk(clk), .nRST(nRST), .bus(if2));
  matrix_result_tx #(.CLKS_PER_BIT(16)) dut16 (.clk(clk), .nRST(nRST), .bus(if16));

  // Scoreboard: expected frame bytes and the serial bit sequence they imply
  logic [7:0] exp_q[$];
  logic       exp_bits[60];
  logic       rec[960];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cpb_of(input int sel);
    case (sel)
      0:       return 4;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  function automatic logic rd_tx(input int sel);
    case (sel)
      0:       return if4.tx;
      1:       return if2.tx;
      default: return if16.tx;
    endcase
  endfunction

  function automatic logic rd_busy(input int sel);
    case (sel)
      0:       return if4.busy;
      1:       return if2.busy;
      default: return if16.busy;
    endcase
  endfunction

  function automatic logic rd_done(input int sel);
    case (sel)
      0:       return if4.done;
      1:       return if2.done;
      default: return if16.done;
    endcase
  endfunction

  function automatic tx_state_t rd_state(input int sel);
    case (sel)
      0:       return if4.dbg_state;
      1:       return if2.dbg_state;
      default: return if16.dbg_state;
    endcase
  endfunction

  // Driver tasks
  task automatic set_send(input int sel, input logic s);
    case (sel)
      0:       if4.send = s;
      1:       if2.send = s;
      default: if16.send = s;
    endcase
  endtask

  task automatic set_in(input int sel, input logic s, input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input logic [7:0] c3);
    case (sel)
      0:       begin if4.send = s;  if4.C00 = c0;  if4.C01 = c1;  if4.C10 = c2;  if4.C11 = c3;  end
      1:       begin if2.send = s;  if2.C00 = c0;  if2.C01 = c1;  if2.C10 = c2;  if2.C11 = c3;  end
      default: begin if16.send = s; if16.C00 = c0; if16.C01 = c1; if16.C10 = c2; if16.C11 = c3; end
    endcase
  endtask

  task automatic start_send(input int sel, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
    @(negedge clk);
    set_in(sel, 1'b1, c0, c1, c2, c3);
  endtask

  // Reference model: frame bytes, then 60 bit slots of start/data(LSB first)/stop.
  task automatic model_frame(input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3);
    int         sum;
    logic [7:0] b;
    sum = int'(c0) + int'(c1) + int'(c2) + int'(c3);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(c0);
    exp_q.push_back(c1);
    exp_q.push_back(c2);
    exp_q.push_back(c3);
    exp_q.push_back(8'(sum % 256));
    for (int n = 0; n < 60; n++) begin
      b = exp_q[n / 10];
      if (n % 10 == 0)      exp_bits[n] = 1'b0;
      else if (n % 10 == 9) exp_bits[n] = 1'b1;
      else                  exp_bits[n] = b[(n % 10) - 1];
    end
  endtask

  // Follows one frame from the cycle after the accepting edge through the done cycle.
  // perturb >= 0: at that cycle, pulse send with new random C values.
  task automatic check_frame(input int sel, input string name, input logic hold, input int perturb,
                             input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [7:0] c3);
    int         cpb;
    int         mid;
    int         base;
    int         tx_bad;
    int         busy_bad;
    int         done_bad;
    int         busy_cnt;
    logic [7:0] got;
    logic [7:0] exp;
    cpb      = cpb_of(sel);
    mid      = cpb / 2;
    tx_bad   = 0;
    busy_bad = 0;
    done_bad = 0;
    busy_cnt = 0;
    model_frame(c0, c1, c2, c3);
    @(negedge clk);
    set_send(sel, hold);
    for (int k = 0; k < 60 * cpb; k++) begin
      if (k == perturb)
        set_in(sel, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      else if (k == perturb + 1)
        set_send(sel, hold);
      rec[k] = rd_tx(sel);
      if (rec[k] !== exp_bits[k / cpb]) tx_bad++;
      if (rd_busy(sel) !== 1'b1) busy_bad++;
      else busy_cnt++;
      if (rd_done(sel) !== 1'b0) done_bad++;
      @(negedge clk);
    end
    check($sformatf("%s_tx_wave_bad_cycles", name), 32'(tx_bad), 32'd0);
    check($sformatf("%s_busy_low_cycles", name), 32'(busy_bad), 32'd0);
    check($sformatf("%s_early_done_cycles", name), 32'(done_bad), 32'd0);
    check($sformatf("%s_frame_len", name), 32'(busy_cnt), 32'(60 * cpb));
    for (int b = 0; b < 6; b++) begin
      base = b * 10 * cpb;
      for (int i = 0; i < 8; i++) got[i] = rec[base + (i + 1) * cpb + mid];
      exp = exp_q.pop_front();
      check($sformatf("%s_start%0d", name, b), 32'(rec[base + mid]), 32'd0);
      check($sformatf("%s_byte%0d", name, b), 32'(got), 32'(exp));
      check($sformatf("%s_stop%0d", name, b), 32'(rec[base + 9 * cpb + mid]), 32'd1);
    end
    check($sformatf("%s_done_pulse", name), 32'(rd_done(sel)), 32'd1);
    check($sformatf("%s_busy_in_done", name), 32'(rd_busy(sel)), 32'd0);
    check($sformatf("%s_tx_in_done", name), 32'(rd_tx(sel)), 32'd1);
    check($sformatf("%s_state_in_done", name), 32'(rd_state(sel)), 32'(IDLE));
  endtask

  task automatic check_quiet(input int sel, input string name, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (rd_busy(sel) !== 1'b0 || rd_tx(sel) !== 1'b1 || rd_done(sel) !== 1'b0) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  logic [7:0] r0, r1, r2, r3;

  initial begin
    nRST = 1'b0;
    set_in(0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    set_in(1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    set_in(2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    // Reset state
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_tx%0d", s), 32'(rd_tx(s)), 32'd1);
      check($sformatf("rst_busy%0d", s), 32'(rd_busy(s)), 32'd0);
      check($sformatf("rst_done%0d", s), 32'(rd_done(s)), 32'd0);
      check($sformatf("rst_state%0d", s), 32'(rd_state(s)), 32'(IDLE));
    end
    nRST = 1'b1;
    check_quiet(0, "idle_after_release", 8);

    // Directed frame 1,2,3,4 and checksum wrap cases
    start_send(0, 8'h01, 8'h02, 8'h03, 8'h04);
    check_frame(0, "basic", 1'b0, -1, 8'h01, 8'h02, 8'h03, 8'h04);
    start_send(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check_frame(0, "all_ff", 1'b0, -1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    start_send(0, 8'h00, 8'h00, 8'h00, 8'h00);
    check_frame(0, "all_00", 1'b0, -1, 8'h00, 8'h00, 8'h00, 8'h00);

    // Random frames
    for (int n = 0; n < 3; n++) begin
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      r3 = 8'($urandom_range(0, 255));
      start_send(0, r0, r1, r2, r3);
      check_frame(0, $sformatf("rand%0d", n), 1'b0, -1, r0, r1, r2, r3);
    end

    // Inputs and send changed mid-frame must not disturb it or queue another
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    r3 = 8'($urandom_range(0, 255));
    start_send(0, r0, r1, r2, r3);
    check_frame(0, "perturb", 1'b0, 50, r0, r1, r2, r3);
    check_quiet(0, "no_second_frame", 12);

    // send held high: frames back-to-back, next start bit right after done
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    r3 = 8'($urandom_range(0, 255));
    start_send(0, r0, r1, r2, r3);
    check_frame(0, "held1", 1'b1, -1, r0, r1, r2, r3);
    check_frame(0, "held2", 1'b1, -1, r0, r1, r2, r3);
    check_frame(0, "held3", 1'b0, -1, r0, r1, r2, r3);
    check_quiet(0, "held_stops", 6);

    // Reset in the middle of a frame
    model_frame(8'h11, 8'h02, 8'h33, 8'h44);
    start_send(0, 8'h11, 8'h02, 8'h33, 8'h44);
    @(negedge clk);
    set_send(0, 1'b0);
    repeat (100) @(negedge clk);
    check("pre_rst_busy", 32'(rd_busy(0)), 32'd1);
    check("pre_rst_tx", 32'(rd_tx(0)), 32'(exp_bits[100 / 4]));
    #2 nRST = 1'b0;
    #1;
    check("async_rst_tx", 32'(rd_tx(0)), 32'd1);
    check("async_rst_busy", 32'(rd_busy(0)), 32'd0);
    check("async_rst_done", 32'(rd_done(0)), 32'd0);
    check_quiet(0, "held_in_reset", 3);
    nRST = 1'b1;
    check_quiet(0, "idle_after_abort", 10);
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    r3 = 8'($urandom_range(0, 255));
    start_send(0, r0, r1, r2, r3);
    check_frame(0, "after_abort", 1'b0, -1, r0, r1, r2, r3);

    // Other bit rates
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    r3 = 8'($urandom_range(0, 255));
    start_send(1, r0, r1, r2, r3);
    check_frame(1, "cpb2", 1'b0, -1, r0, r1, r2, r3);
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    r3 = 8'($urandom_range(0, 255));
    start_send(2, r0, r1, r2, r3);
    check_frame(2, "cpb16", 1'b0, -1, r0, r1, r2, r3);

    // Report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
